// File: rtl/clock_gate_pkg.sv
// Shared types for the multi-channel clock-gating controller.
package clock_gate_pkg;

  localparam int NCH_MAX = 32;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_GATED = 3'd2,
    ST_WAKE  = 3'd3,
    ST_REL   = 3'd4
  } gate_state_e;

  // Per-channel outputs, registered together so they always agree with the state.
  typedef struct packed {
    logic clk_en;
    logic qreq;
    logic ready;
    logic gated;
  } chan_out_t;

  // Output decode of a state; the FSM registers this value for its next state.
  function automatic chan_out_t state_outputs(gate_state_e s);
    chan_out_t o;
    o = '{clk_en: 1'b1, qreq: 1'b0, ready: 1'b1, gated: 1'b0};
    case (s)
      ST_RUN:   o = '{clk_en: 1'b1, qreq: 1'b0, ready: 1'b1, gated: 1'b0};
      ST_DRAIN: o = '{clk_en: 1'b1, qreq: 1'b1, ready: 1'b1, gated: 1'b0};
      ST_GATED: o = '{clk_en: 1'b0, qreq: 1'b1, ready: 1'b0, gated: 1'b1};
      ST_WAKE:  o = '{clk_en: 1'b1, qreq: 1'b1, ready: 1'b0, gated: 1'b0};
      ST_REL:   o = '{clk_en: 1'b1, qreq: 1'b0, ready: 1'b0, gated: 1'b0};
      default:  o = '{clk_en: 1'b1, qreq: 1'b0, ready: 1'b1, gated: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/EICG_wrapper.sv
// Latch-based integrated clock gate. The enable is captured while the source
// clock is low, so a change of enable never produces a runt pulse.
module EICG_wrapper (
  output logic out,
  input  logic in,
  input  logic en,
  input  logic test_en
);

  logic en_latched;

  // Transparent while the source clock is low, holds while it is high.
  always_latch begin
    if (!in) en_latched = en | test_en;
  end

  assign out = in & en_latched;

endmodule

// File: rtl/clock_gate_chan.sv
// One gating channel: idle counter, quiesce handshake FSM and registered
// gate enable.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | clock running, counting consecutive idle cycles
//   ST_DRAIN | qreq raised, waiting for qack (aborts on any activity)
//   ST_GATED | clock stopped, handshake held
//   ST_WAKE  | clock re-enabled, settling for WAKE_CYC cycles
//   ST_REL   | qreq dropped, waiting for qack to fall
module clock_gate_chan
  import clock_gate_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             busy_i,
  input  logic             wake_i,
  input  logic             auto_en_i,
  input  logic             qack_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             clk_en_o,
  output logic             qreq_o,
  output logic             ready_o,
  output logic             gated_o
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'((WAKE_CYC > 1) ? WAKE_CYC - 1 : 0);

  gate_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  chan_out_t        out_q;
  logic             activity;
  logic             thresh_zero;
  logic             cnt_sat;

  // Next-state and counter update; the counter is reused as the WAKE timer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    activity    = busy_i | wake_i | ~auto_en_i;
    thresh_zero = (thresh_i == '0);
    cnt_sat     = &cnt_q;
    case (state_q)
      ST_RUN: begin
        if (activity || thresh_zero) begin
          cnt_d = '0;
        end else if (cnt_q == (thresh_i - CNT_ONE)) begin
          // thresh-th consecutive idle cycle: start the handshake
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else if (!cnt_sat) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        // Activity wins over a coincident acknowledge.
        if (activity) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (qack_i) begin
          state_d = ST_GATED;
        end
      end
      ST_GATED: begin
        if (activity) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = ST_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REL: begin
        if (!qack_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset abandons any handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      out_q   <= state_outputs(ST_RUN);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= state_outputs(state_d);
    end
  end

  assign clk_en_o = out_q.clk_en;
  assign qreq_o   = out_q.qreq;
  assign ready_o  = out_q.ready;
  assign gated_o  = out_q.gated;

endmodule

// File: rtl/clock_gate_ctrl.sv
// Multi-channel clock-gating controller: NCH independent gating channels,
// each driving its own latch-based clock gate.
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             test_en,
  input  logic [CNT_W-1:0] cfg_idle_thresh,
  input  logic [NCH-1:0]   cfg_auto_en,
  input  logic [NCH-1:0]   busy,
  input  logic [NCH-1:0]   wake,
  input  logic [NCH-1:0]   qack,
  output logic [NCH-1:0]   qreq,
  output logic [NCH-1:0]   gclk,
  output logic [NCH-1:0]   clk_en,
  output logic [NCH-1:0]   ready,
  output logic [NCH-1:0]   gated
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clock_gate_chan #(
      .CNT_W    (CNT_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_chan (
      .clk_i     (clock),
      .rst_i     (reset),
      .busy_i    (busy[i]),
      .wake_i    (wake[i]),
      .auto_en_i (cfg_auto_en[i]),
      .qack_i    (qack[i]),
      .thresh_i  (cfg_idle_thresh),
      .clk_en_o  (clk_en[i]),
      .qreq_o    (qreq[i]),
      .ready_o   (ready[i]),
      .gated_o   (gated[i])
    );

    EICG_wrapper u_icg (
      .out     (gclk[i]),
      .in      (clock),
      .en      (clk_en[i]),
      .test_en (test_en)
    );
  end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Bench for clock_gate_ctrl: a per-cycle reference model feeds a scoreboard
// queue, and a table of phases checks hand-derived end-of-phase values.
module tb_clock_gate_ctrl;

  localparam int NCH      = 4;
  localparam int CNT_W    = 8;
  localparam int WAKE_CYC = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             test_en = 1'b0;
  logic [CNT_W-1:0] cfg_idle_thresh = 8'd4;
  logic [NCH-1:0]   cfg_auto_en = 4'hF;
  logic [NCH-1:0]   busy = 4'hF;
  logic [NCH-1:0]   wake = 4'h0;
  logic [NCH-1:0]   qack;
  logic [NCH-1:0]   qreq, gclk, clk_en, ready, gated;
  logic [NCH-1:0]   qack_reg = 4'h0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Channel side: qack echoes qreq one cycle late.
  always @(posedge clock) qack_reg <= qreq;
  assign qack = qack_reg;

  clock_gate_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .WAKE_CYC(WAKE_CYC)) dut (
    .clock           (clock),
    .reset           (reset),
    .test_en         (test_en),
    .cfg_idle_thresh (cfg_idle_thresh),
    .cfg_auto_en     (cfg_auto_en),
    .busy            (busy),
    .wake            (wake),
    .qack            (qack),
    .qreq            (qreq),
    .gclk            (gclk),
    .clk_en          (clk_en),
    .ready           (ready),
    .gated           (gated)
  );

  // Count gated-clock high phases per channel.
  int gcnt [NCH];
  initial for (int i = 0; i < NCH; i++) gcnt[i] = 0;
  always @(posedge clock) begin
    #2;
    for (int i = 0; i < NCH; i++) if (gclk[i]) gcnt[i] = gcnt[i] + 1;
  end

  // Reference model: 0 RUN, 1 DRAIN, 2 GATED, 3 WAKE, 4 REL
  int ms [NCH];
  int mc [NCH];
  logic [15:0] exp_q [$];

  task automatic model_step();
    logic [3:0] e_en, e_qr, e_rd, e_gt;
    logic act;
    int thr;
    thr = int'(cfg_idle_thresh);
    for (int i = 0; i < NCH; i++) begin
      act = busy[i] | wake[i] | ~cfg_auto_en[i];
      if (reset) begin
        ms[i] = 0; mc[i] = 0;
      end else begin
        case (ms[i])
          0: if (act || thr == 0) mc[i] = 0;
             else if (mc[i] == thr - 1) begin ms[i] = 1; mc[i] = 0; end
             else if (mc[i] < 255) mc[i] = mc[i] + 1;
          1: if (act) begin ms[i] = 0; mc[i] = 0; end
             else if (qack[i]) ms[i] = 2;
          2: if (act) begin ms[i] = 3; mc[i] = 0; end
          3: if (mc[i] == WAKE_CYC - 1) begin ms[i] = 4; mc[i] = 0; end
             else mc[i] = mc[i] + 1;
          default: if (!qack[i]) begin ms[i] = 0; mc[i] = 0; end
        endcase
      end
      e_en[i] = (ms[i] != 2);
      e_qr[i] = (ms[i] == 1) || (ms[i] == 2) || (ms[i] == 3);
      e_rd[i] = (ms[i] <= 1);
      e_gt[i] = (ms[i] == 2);
    end
    exp_q.push_back({e_en, e_qr, e_rd, e_gt});
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_check();
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 16'h0001, 16'h0000);
    end else begin
      e = exp_q.pop_front();
      chk("sb_cycle", {clk_en, qreq, ready, gated}, e);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] busy;
    logic [3:0] wake;
    logic [3:0] auto_en;
    logic [7:0] thr;
    logic       tst;
    int         ncyc;
    logic [3:0] en;
    logic [3:0] qr;
    logic [3:0] rd;
    logic [3:0] gt;
    logic       gchk;
    logic [3:0] gmask;
  } vec_t;

  vec_t tab [20];

  initial begin
    int snap [NCH];
    for (int i = 0; i < NCH; i++) begin ms[i] = 0; mc[i] = 0; snap[i] = 0; end
    //          rst   busy  wake  auto  thr    tst  n     en    qr    rd    gt    gchk  gmask
    tab[0]  = '{1'b1, 4'h0, 4'h0, 4'hF, 8'd4, 1'b0, 3,    4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 4'hF};
    tab[1]  = '{1'b0, 4'hF, 4'h0, 4'hF, 8'd4, 1'b0, 5,    4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 4'hF};
    tab[2]  = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd4, 1'b0, 20,   4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 4'h0};
    tab[3]  = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd4, 1'b1, 4,    4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 4'hF};
    tab[4]  = '{1'b0, 4'h0, 4'h1, 4'hF, 8'd4, 1'b0, 1,    4'h1, 4'hF, 4'h0, 4'hE, 1'b0, 4'h0};
    tab[5]  = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd4, 1'b0, 1,    4'h1, 4'hF, 4'h0, 4'hE, 1'b0, 4'h0};
    tab[6]  = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd4, 1'b0, 1,    4'h1, 4'hE, 4'h0, 4'hE, 1'b0, 4'h0};
    tab[7]  = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd4, 1'b0, 1,    4'h1, 4'hE, 4'h0, 4'hE, 1'b0, 4'h0};
    tab[8]  = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd4, 1'b0, 1,    4'h1, 4'hE, 4'h1, 4'hE, 1'b0, 4'h0};
    tab[9]  = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd4, 1'b0, 4,    4'h1, 4'hF, 4'h1, 4'hE, 1'b0, 4'h0};
    tab[10] = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd4, 1'b0, 1,    4'h1, 4'hF, 4'h1, 4'hE, 1'b0, 4'h0};
    tab[11] = '{1'b0, 4'h1, 4'h0, 4'hF, 8'd4, 1'b0, 1,    4'h1, 4'hE, 4'h1, 4'hE, 1'b0, 4'h0};
    tab[12] = '{1'b0, 4'h1, 4'h0, 4'hD, 8'd4, 1'b0, 6,    4'h3, 4'hC, 4'h3, 4'hC, 1'b0, 4'h0};
    tab[13] = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd0, 1'b0, 1000, 4'h3, 4'hC, 4'h3, 4'hC, 1'b1, 4'h3};
    tab[14] = '{1'b0, 4'h0, 4'h0, 4'hE, 8'd4, 1'b0, 1000, 4'h1, 4'hE, 4'h1, 4'hE, 1'b1, 4'h1};
    tab[15] = '{1'b0, 4'h0, 4'h4, 4'hF, 8'd2, 1'b0, 2,    4'h5, 4'hF, 4'h1, 4'hA, 1'b0, 4'h0};
    tab[16] = '{1'b1, 4'h0, 4'h0, 4'hF, 8'd2, 1'b0, 1,    4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 4'h0};
    tab[17] = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd4, 1'b0, 3,    4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 4'hF};
    tab[18] = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd4, 1'b0, 1,    4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 4'h0};
    tab[19] = '{1'b0, 4'h0, 4'h0, 4'hF, 8'd4, 1'b0, 4,    4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 4'h0};

    @(negedge clock);
    for (int r = 0; r < 20; r++) begin
      reset           = tab[r].rst;
      busy            = tab[r].busy;
      wake            = tab[r].wake;
      cfg_auto_en     = tab[r].auto_en;
      cfg_idle_thresh = tab[r].thr;
      test_en         = tab[r].tst;
      for (int k = 0; k < tab[r].ncyc; k++) begin
        if (k == tab[r].ncyc - 2)
          for (int i = 0; i < NCH; i++) snap[i] = gcnt[i];
        model_step();
        @(posedge clock);
        @(negedge clock);
        sb_check();
      end
      chk($sformatf("row%0d_clk_en", r), {12'h0, clk_en}, {12'h0, tab[r].en});
      chk($sformatf("row%0d_qreq", r),   {12'h0, qreq},   {12'h0, tab[r].qr});
      chk($sformatf("row%0d_ready", r),  {12'h0, ready},  {12'h0, tab[r].rd});
      chk($sformatf("row%0d_gated", r),  {12'h0, gated},  {12'h0, tab[r].gt});
      if (tab[r].gchk) begin
        for (int i = 0; i < NCH; i++)
          chk($sformatf("row%0d_gclk_pulses_ch%0d", r, i),
              16'(gcnt[i] - snap[i]), tab[r].gmask[i] ? 16'd2 : 16'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
